// File: rtl/cms_pkg.sv
// Shared widths and state encoding for the frame scheduler that time-shares one
// complex_mean_square engine between several requesters.
package cms_pkg;

  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned RESULT_W = 64;
  localparam int unsigned LOG2_W   = 3;
  localparam int unsigned CNT_W    = 9;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t ARB       = 3'd1;
  localparam state_t START     = 3'd2;
  localparam state_t WAIT_INIT = 3'd3;
  localparam state_t STREAM    = 3'd4;
  localparam state_t DRAIN     = 3'd5;
  localparam state_t DONE      = 3'd6;

endpackage

// File: rtl/cms_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after the pointer,
// searched cyclically so non-power-of-2 requester counts wrap correctly.
module cms_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  pointer,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             any_req
);

  int              idx;
  logic [ID_W-1:0] sel;
  logic            found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any_req  = |req;
    found    = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = int'(pointer) + i;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      sel = ID_W'(idx);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        grant_id   = sel;
      end
    end
  end

endmodule

// File: rtl/cms_frame_scheduler.sv
// Grants the shared mean-square engine to one requester per frame, streams its
// 2^log2 samples, and returns the engine result (or a watchdog abort) tagged by ID.
module cms_frame_scheduler
  import cms_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [LOG2_W*N_REQ-1:0]     i_log2_samples,
  input  logic [N_REQ-1:0]            i_valid,
  input  logic [SAMPLE_W*N_REQ-1:0]   i_y,
  input  logic [SAMPLE_W*N_REQ-1:0]   i_y_hat,
  output logic [N_REQ-1:0]            o_ready,
  output logic [N_REQ-1:0]            o_grant,
  output logic                        o_cms_en,
  output logic [LOG2_W-1:0]           o_cms_log2_samples,
  output logic                        o_cms_valid,
  output logic [SAMPLE_W-1:0]         o_cms_y,
  output logic [SAMPLE_W-1:0]         o_cms_y_hat,
  input  logic                        i_cms_valid,
  input  logic [RESULT_W-1:0]         i_cms_data,
  output logic                        o_res_valid,
  input  logic                        i_res_ready,
  output logic [RESULT_W-1:0]         o_res_data,
  output logic [ID_W-1:0]             o_res_id,
  output logic                        o_res_err,
  output logic                        o_busy
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [LOG2_W-1:0]   log2_q, log2_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [RESULT_W-1:0] res_q, res_d;
  logic                err_q, err_d;

  logic [N_REQ-1:0]    arb_grant;
  logic [ID_W-1:0]     arb_id;
  logic                arb_any;
  logic [LOG2_W-1:0]   arb_log2;

  logic                sel_valid;
  logic [SAMPLE_W-1:0] sel_y, sel_y_hat;
  logic [CNT_W-1:0]    frame_len, cnt_inc;
  logic                room, xfer;

  cms_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req      (i_req),
    .pointer  (ptr_q),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any_req  (arb_any)
  );

  // Slice selection: the latched grant drives the stream, the live arbiter pick the log2 latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_y     = '0;
    sel_y_hat = '0;
    arb_log2  = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (ID_W'(k) == id_q) begin
        sel_valid = i_valid[k];
        sel_y     = i_y[k*SAMPLE_W +: SAMPLE_W];
        sel_y_hat = i_y_hat[k*SAMPLE_W +: SAMPLE_W];
      end
      if (ID_W'(k) == arb_id) arb_log2 = i_log2_samples[k*LOG2_W +: LOG2_W];
    end
  end

  assign frame_len = CNT_W'(1) << log2_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign room      = cnt_q < frame_len;
  assign xfer      = (state_q == STREAM) && room && sel_valid;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      log2_q  <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      log2_q  <= log2_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    log2_d  = log2_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (arb_any) state_d = ARB;
      ARB: begin
        // A request withdrawn before arbitration simply returns to IDLE.
        if (arb_any) begin
          id_d    = arb_id;
          log2_d  = arb_log2;
          grant_d = arb_grant;
          cnt_d   = '0;
          wd_d    = '0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START:     state_d = WAIT_INIT;
      WAIT_INIT: state_d = STREAM;
      STREAM: begin
        if (xfer) begin
          cnt_d = cnt_inc;
          if (cnt_inc == frame_len) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (i_cms_valid) begin
          res_d   = i_cms_data;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      DONE: begin
        if (i_res_ready) begin
          ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready            = '0;
    o_cms_en           = 1'b0;
    o_cms_log2_samples = '0;
    o_cms_valid        = 1'b0;
    o_cms_y            = '0;
    o_cms_y_hat        = '0;
    o_res_valid        = 1'b0;
    if (state_q == STREAM && room) o_ready = grant_q;
    if (state_q == START) o_cms_en = 1'b1;
    if (state_q != IDLE && state_q != ARB) o_cms_log2_samples = log2_q;
    if (xfer) begin
      o_cms_valid = 1'b1;
      o_cms_y     = sel_y;
      o_cms_y_hat = sel_y_hat;
    end
    if (state_q == DONE) o_res_valid = 1'b1;
    o_grant    = grant_q;
    o_res_data = res_q;
    o_res_id   = id_q;
    o_res_err  = err_q;
    o_busy     = (state_q != IDLE);
  end

endmodule

// File: tb/tb_cms_frame_scheduler.sv
// Directed bench for cms_frame_scheduler: arbitration order, streaming counts,
// watchdog abort, result hold under backpressure and asynchronous reset.
module tb_cms_frame_scheduler;

  logic         i_clk = 1'b0;
  logic         i_arst_n;
  logic [3:0]   i_req;
  logic [11:0]  i_log2_samples;
  logic [3:0]   i_valid;
  logic [127:0] i_y;
  logic [127:0] i_y_hat;
  logic [3:0]   o_ready;
  logic [3:0]   o_grant;
  logic         o_cms_en;
  logic [2:0]   o_cms_log2_samples;
  logic         o_cms_valid;
  logic [31:0]  o_cms_y;
  logic [31:0]  o_cms_y_hat;
  logic         i_cms_valid;
  logic [63:0]  i_cms_data;
  logic         o_res_valid;
  logic         i_res_ready;
  logic [63:0]  o_res_data;
  logic [1:0]   o_res_id;
  logic         o_res_err;
  logic         o_busy;

  int          checks = 0;
  int          errors = 0;
  bit          drop_req = 1'b0;
  logic [31:0] ybank  [4];
  logic [31:0] yhbank [4];

  localparam logic [63:0] Junk = 64'hDEAD_BEEF_DEAD_BEEF;

  always #5 i_clk = ~i_clk;

  cms_frame_scheduler #(
    .N_REQ          (4),
    .ID_W           (2),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .i_clk              (i_clk),
    .i_arst_n           (i_arst_n),
    .i_req              (i_req),
    .i_log2_samples     (i_log2_samples),
    .i_valid            (i_valid),
    .i_y                (i_y),
    .i_y_hat            (i_y_hat),
    .o_ready            (o_ready),
    .o_grant            (o_grant),
    .o_cms_en           (o_cms_en),
    .o_cms_log2_samples (o_cms_log2_samples),
    .o_cms_valid        (o_cms_valid),
    .o_cms_y            (o_cms_y),
    .o_cms_y_hat        (o_cms_y_hat),
    .i_cms_valid        (i_cms_valid),
    .i_cms_data         (i_cms_data),
    .o_res_valid        (o_res_valid),
    .i_res_ready        (i_res_ready),
    .o_res_data         (o_res_data),
    .o_res_id           (o_res_id),
    .o_res_err          (o_res_err),
    .o_busy             (o_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #2;
  endtask

  // Runs one frame starting from IDLE with the requests already applied.
  task automatic do_frame(input int id, input int lg, input logic [15:0] vpat, input int ncyc,
                          input bit respond, input logic [63:0] res, input int hold);
    int         n;
    int         sent;
    int         c;
    logic [3:0] gmask;
    logic       v;
    n     = 1 << lg;
    sent  = 0;
    gmask = 4'(1 << id);

    cyc();
    check("arb_busy", 64'(o_busy), 64'd1);
    check("arb_no_en", 64'(o_cms_en), 64'd0);
    check("arb_no_grant", 64'(o_grant), 64'd0);
    cyc();
    check("start_grant", 64'(o_grant), 64'(gmask));
    check("start_en", 64'(o_cms_en), 64'd1);
    check("start_log2", 64'(o_cms_log2_samples), 64'(lg));
    if (drop_req) i_req = i_req & ~gmask;
    i_cms_valid = 1'b1;
    i_cms_data  = Junk;
    cyc();
    i_cms_valid = 1'b0;
    #1;
    check("init_ready", 64'(o_ready), 64'd0);
    check("init_no_en", 64'(o_cms_en), 64'd0);
    cyc();
    for (c = 0; c < ncyc; c++) begin
      v       = vpat[c[3:0]];
      i_valid = v ? 4'hF : ~gmask;
      #1;
      if (sent < n) begin
        check("stream_ready", 64'(o_ready), 64'(gmask));
        check("stream_fwd", 64'(o_cms_valid), 64'(v));
        if (v) begin
          check("stream_y", 64'(o_cms_y), 64'(ybank[id]));
          check("stream_y_hat", 64'(o_cms_y_hat), 64'(yhbank[id]));
          sent++;
        end
      end else begin
        check("full_ready_off", 64'(o_ready), 64'd0);
        check("full_no_fwd", 64'(o_cms_valid), 64'd0);
      end
      cyc();
    end
    i_valid = '0;

    if (respond) begin
      #1;
      check("drain_wait", 64'(o_res_valid), 64'd0);
      i_cms_valid = 1'b1;
      i_cms_data  = res;
      cyc();
      i_cms_valid = 1'b0;
      i_cms_data  = '0;
    end else begin
      // ncyc = n+1 leaves one DRAIN cycle already elapsed here
      c = 1;
      while (!o_res_valid && c < 100) begin
        cyc();
        c++;
      end
      check("watchdog_cycles", 64'(c), 64'd64);
    end

    #1;
    check("res_valid", 64'(o_res_valid), 64'd1);
    check("res_data", o_res_data, respond ? res : 64'd0);
    check("res_id", 64'(o_res_id), 64'(id));
    check("res_err", 64'(o_res_err), respond ? 64'd0 : 64'd1);
    for (c = 0; c < hold; c++) begin
      i_req = 4'hF;
      cyc();
      check("hold_data", o_res_data, respond ? res : 64'd0);
      check("hold_ctl", 64'({o_res_valid, o_res_err, o_res_id, o_grant}),
            64'({1'b1, !respond, 2'(id), gmask}));
    end
    i_res_ready = 1'b1;
    cyc();
    i_res_ready = 1'b0;
    #1;
    check("idle_grant", 64'(o_grant), 64'd0);
    check("idle_busy", 64'(o_busy), 64'd0);
    check("idle_res_valid", 64'(o_res_valid), 64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    i_arst_n       = 1'b0;
    i_req          = '0;
    i_log2_samples = '0;
    i_valid        = '0;
    i_cms_valid    = 1'b0;
    i_cms_data     = '0;
    i_res_ready    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ybank[k]  = 32'h1111_0000 * 32'(k + 1) + 32'(k + 1);
      yhbank[k] = 32'hA000_0000 + 32'h0101_0101 * 32'(k + 1);
      i_y[k*32 +: 32]     = ybank[k];
      i_y_hat[k*32 +: 32] = yhbank[k];
    end

    #1;
    check("rst_grant", 64'(o_grant), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_res", 64'({o_res_valid, o_res_err, o_res_id}), 64'd0);
    check("rst_res_data", o_res_data, 64'd0);
    check("rst_engine", 64'({o_cms_en, o_cms_valid, o_cms_log2_samples, o_ready}), 64'd0);
    #20;
    i_arst_n = 1'b1;
    cyc();
    check("idle_no_req", 64'(o_busy), 64'd0);

    // Single requester, four back-to-back samples
    i_req          = 4'b0001;
    i_log2_samples = {3'd0, 3'd0, 3'd0, 3'd2};
    do_frame(0, 2, 16'hFFFF, 5, 1'b1, 64'h0000_0005_0000_0003, 0);
    i_req = '0;

    // Reset asserted mid-stream; the pointer (now 1) must return to 0
    i_req          = 4'b0100;
    i_log2_samples = {3'd0, 3'd3, 3'd0, 3'd0};
    cyc();
    cyc();
    check("rst_test_grant", 64'(o_grant), 64'b0100);
    i_req = '0;
    cyc();
    cyc();
    i_valid = 4'hF;
    #1;
    check("rst_test_fwd", 64'(o_cms_valid), 64'd1);
    cyc();
    i_arst_n = 1'b0;
    #1;
    check("async_grant", 64'(o_grant), 64'd0);
    check("async_busy", 64'(o_busy), 64'd0);
    check("async_stream", 64'({o_ready, o_cms_valid, o_cms_en}), 64'd0);
    check("async_y", 64'(o_cms_y), 64'd0);
    check("async_res", 64'({o_res_valid, o_res_err}), 64'd0);
    i_valid = '0;
    cyc();
    i_arst_n = 1'b1;

    // All requesting, one-sample frames: order 0,1,2,3,0
    i_req          = 4'hF;
    i_log2_samples = '0;
    do_frame(0, 0, 16'hFFFF, 2, 1'b1, 64'h0000_00A0, 0);
    do_frame(1, 0, 16'hFFFF, 2, 1'b1, 64'h0000_00A1, 0);
    do_frame(2, 0, 16'hFFFF, 2, 1'b1, 64'h0000_00A2, 0);
    do_frame(3, 0, 16'hFFFF, 2, 1'b1, 64'h0000_00A3, 0);
    do_frame(0, 0, 16'hFFFF, 2, 1'b1, 64'h0000_00A4, 0);
    i_req = '0;

    // Requester 2, eight samples with gaps, request dropped mid-frame, extra valid ignored
    i_req          = 4'b0100;
    i_log2_samples = {3'd0, 3'd3, 3'd0, 3'd0};
    drop_req       = 1'b1;
    do_frame(2, 3, 16'b1110_1110_1101_1011, 12, 1'b1, 64'h1234_5678_9ABC_DEF0, 0);
    drop_req = 1'b0;

    // Engine never answers: watchdog abort, then requester 0 is served next
    i_req          = 4'b1001;
    i_log2_samples = '0;
    do_frame(3, 0, 16'hFFFF, 2, 1'b0, 64'd0, 0);

    // Result held under backpressure for 10 cycles while everyone requests
    do_frame(0, 0, 16'hFFFF, 2, 1'b1, 64'h0000_0007_0000_0009, 10);
    cyc();
    check("post_hold_arb", 64'(o_grant), 64'd0);
    cyc();
    check("post_hold_grant", 64'(o_grant), 64'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cms_frame_scheduler.md
Name: cms_frame_scheduler

Overview:
- Shares one complex_mean_square datapath (engine) between N requesters, one frame at a time.
- A round-robin arbiter grants one requester, which gets exclusive use of the engine for a whole frame.
- The block configures and starts the engine, forwards exactly 2^log2 samples to it, captures the engine's one-cycle result pulse, and returns the result to the granted requester through a valid/ready handshake, tagged with the requester ID.
- A drain watchdog aborts a frame whose result never arrives.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; equals clog2(N_REQ).
- TIMEOUT_CYCLES, 64, maximum number of cycles in DRAIN before the frame is aborted.

Ports:
- i_clk  in  1  clock.
- i_arst_n  in  1  asynchronous active-low reset.
- i_req  in  N_REQ  per-requester frame request; the requester holds it high until granted.
- i_log2_samples  in  3*N_REQ  per-requester frame length as log2; slice k belongs to requester k.
- i_valid  in  N_REQ  per-requester sample valid.
- i_y  in  32*N_REQ  per-requester measured sample {re[31:16], im[15:0]}.
- i_y_hat  in  32*N_REQ  per-requester estimated sample.
- o_ready  out  N_REQ  per-requester sample ready; only the granted requester's bit can be high.
- o_grant  out  N_REQ  one-hot grant, held for the whole frame.
- o_cms_en  out  1  engine start pulse.
- o_cms_log2_samples  out  3  engine frame length, stable from START until DONE exits.
- o_cms_valid  out  1  engine sample valid.
- o_cms_y  out  32  engine sample y.
- o_cms_y_hat  out  32  engine sample y_hat.
- i_cms_valid  in  1  engine result pulse.
- i_cms_data  in  64  engine result.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  result ready.
- o_res_data  out  64  mean-square result; zero when o_res_err=1.
- o_res_id  out  ID_W  ID of the requester the result belongs to.
- o_res_err  out  1  frame aborted by the watchdog.
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync deassert):
  - state IDLE; round-robin pointer 0.
  - All outputs 0; internal counters 0.
- States, one register, encoding taken from the package:
  - IDLE: if any bit of i_req is high, go to ARB.
  - ARB, 1 cycle:
    - Choose the first requesting index at or after the pointer, cyclically.
    - Latch the granted ID and that requester's log2 value; the value cannot change until DONE.
    - Set o_grant; go to START.
  - START, 1 cycle: o_cms_en=1, o_cms_log2_samples driven from the latch; go to WAIT_INIT.
  - WAIT_INIT, 1 cycle: matches the engine's init cycle, so no sample is forwarded; go to STREAM.
  - STREAM:
    - o_ready[g] = 1 while sent count < 2^log2.
    - A sample transfers when i_valid[g] and o_ready[g] are both high.
    - On a transfer: o_cms_valid=1 and y/y_hat pass through combinationally from slice g; the count increments.
    - Non-granted requesters see o_ready=0.
    - When the count reaches 2^log2, go to DRAIN; the count is 9 bits, so log2=7 gives 128.
  - DRAIN:
    - Wait for i_cms_valid.
    - On the pulse: capture i_cms_data into o_res_data; o_res_err=0; go to DONE.
    - A watchdog counter increments every cycle in DRAIN. On reaching TIMEOUT_CYCLES: o_res_data=0, o_res_err=1, go to DONE.
  - DONE:
    - o_res_valid=1; hold data, ID and err until i_res_ready.
    - On the handshake: pointer = (ID+1) mod N_REQ; clear o_grant; go to IDLE.
- Request and stream rules:
  - A requester that drops i_req mid-frame does not abort the frame; the scheduler keeps waiting for samples.
  - Any i_cms_valid outside DRAIN is ignored.
  - o_cms_valid is never high outside STREAM.
- Latency:
  - Request to grant: 2 cycles from IDLE (IDLE→ARB→START).
  - Grant to first possible sample: 2 cycles (START, WAIT_INIT).
  - Result pulse to o_res_valid: 1 cycle.
- Back-to-back: the minimum gap between frames is one IDLE cycle; IDLE does not skip directly to ARB.
- Arithmetic: the pointer wraps modulo N_REQ, so non-power-of-2 N_REQ must wrap correctly.

Decomposition:
- Package cms_pkg holds:
  - State encoding localparams: IDLE, ARB, START, WAIT_INIT, STREAM, DRAIN, DONE.
  - SAMPLE_W=32, RESULT_W=64, LOG2_W=3, CNT_W=9.
- Sub-module cms_rr_arbiter (combinational): inputs req and pointer; outputs one-hot grant, grant ID and any_req.

Test Plan:
- Single requester: req0 with log2=2, 4 valid samples back-to-back, engine model returns 0x0000_0005_0000_0003 → exactly 4 o_cms_valid pulses; o_cms_en 2 cycles after req; o_res_data=0x0000_0005_0000_0003, id=0, err=0.
- All 4 requesting continuously, log2=0 → grant order 0,1,2,3,0; each frame forwards exactly 1 sample.
- Requester 2 supplies 8 samples with i_valid gaps, log2=3 → o_ready[2] drops after the 8th sample; the extra 9th i_valid is not forwarded.
- Engine model never responds, TIMEOUT_CYCLES=64 → o_res_valid exactly 64 cycles after entering DRAIN, err=1, data=0; the next requester is then served.
- i_res_ready held low for 10 cycles → data, ID and err stable; no new grant until the handshake.
- i_arst_n asserted mid-STREAM → all outputs 0 immediately; after release, grant restarts from pointer 0.
